// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   Captures 64-bit ALU results with their 5-bit opcode into a small FIFO and
//   drains them onto a 32-bit bus. Multiply/divide results (opcodes 2, 3) go
//   out as two beats (low word, then high word); everything else is a single
//   low-word beat. Opcodes above 13 are illegal: they drain as one beat with
//   zeroed data and bus_err set.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   in_valid/in_ready      ALU-side handshake, in_sel opcode, in_result data
//   bus_valid/bus_ready    bus-side handshake, bus_data beat
//   bus_last, bus_hi       final beat of entry / beat is the high word
//   bus_err, bus_zero      head opcode illegal / head result is zero
//   count                  FIFO occupancy in entries
module alu_result_buffer #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_sel,
   input  logic [63:0]      in_result,
   output logic             bus_valid,
   input  logic             bus_ready,
   output logic [31:0]      bus_data,
   output logic             bus_last,
   output logic             bus_hi,
   output logic             bus_err,
   output logic             bus_zero,
   output logic [PTR_W:0]   count
);

   typedef enum logic {LO, HI} beat_t;

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [63:0]      mem_res [DEPTH];
   logic [4:0]       mem_sel [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   beat_t            state, state_nxt;

   logic        push, pop, free;
   logic        wide;
   logic [63:0] head_res;
   logic [4:0]  head_sel;

   assign head_res = mem_res[rd_ptr];
   assign head_sel = mem_sel[rd_ptr];
   assign wide     = (head_sel == 5'd2) | (head_sel == 5'd3);

   assign in_ready = resetn & (count < FULL_CNT);
   assign push     = in_valid & in_ready;
   assign pop      = bus_valid & bus_ready;

   // Storage carries no reset; only pointers/count/state qualify it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_res[wr_ptr] <= in_result;
         mem_sel[wr_ptr] <= in_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         state  <= LO;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (free) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, free})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Beat FSM and head decode. An entry is freed only on its last beat, so
   // the low beat of a wide result leaves the head in place for the high beat.
   always_comb begin
      state_nxt = state;
      free      = 1'b0;
      bus_valid = 1'b0;
      bus_data  = '0;
      bus_last  = 1'b0;
      bus_hi    = 1'b0;
      bus_err   = 1'b0;
      bus_zero  = 1'b0;
      if (count != '0) begin
         bus_valid = 1'b1;
         bus_err   = head_sel > 5'd13;
         bus_zero  = wide ? (head_res == 64'd0) : (head_res[31:0] == 32'd0);
         case (state)
            LO: begin
               bus_data = bus_err ? 32'd0 : head_res[31:0];
               bus_last = ~wide;
               if (pop) begin
                  if (wide) state_nxt = HI;
                  else      free      = 1'b1;
               end
            end
            HI: begin
               bus_data = head_res[63:32];
               bus_hi   = 1'b1;
               bus_last = 1'b1;
               if (pop) begin
                  state_nxt = LO;
                  free      = 1'b1;
               end
            end
            default: state_nxt = LO;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer
//   Reference model keeps a queue of expected bus beats; each accepted ALU
//   result is expanded into one or two beats when it enters. Occupancy is the
//   number of queued beats marked last.
module tb_alu_result_buffer;

   localparam int DEPTH = 2;
   localparam int PTR_W = 1;

   logic             clk = 1'b0;
   logic             resetn;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_sel;
   logic [63:0]      in_result;
   logic             bus_valid;
   logic             bus_ready;
   logic [31:0]      bus_data;
   logic             bus_last;
   logic             bus_hi;
   logic             bus_err;
   logic             bus_zero;
   logic [PTR_W:0]   count;

   alu_result_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_result (in_result),
      .bus_valid (bus_valid),
      .bus_ready (bus_ready),
      .bus_data  (bus_data),
      .bus_last  (bus_last),
      .bus_hi    (bus_hi),
      .bus_err   (bus_err),
      .bus_zero  (bus_zero),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        hi;
      logic        err;
      logic        zero;
   } beat_t;

   beat_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   bit    did_push;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int entries();
      int n = 0;
      foreach (q[i]) if (q[i].last) n++;
      return n;
   endfunction

   task automatic model_push(input logic [4:0] s, input logic [63:0] r);
      beat_t b;
      if (s > 13) begin
         b = '{32'd0, 1'b1, 1'b0, 1'b1, r[31:0] == 0};
         q.push_back(b);
      end else if (s == 2 || s == 3) begin
         b = '{r[31:0], 1'b0, 1'b0, 1'b0, r == 0};
         q.push_back(b);
         b = '{r[63:32], 1'b1, 1'b1, 1'b0, r == 0};
         q.push_back(b);
      end else begin
         b = '{r[31:0], 1'b1, 1'b0, 1'b0, r[31:0] == 0};
         q.push_back(b);
      end
   endtask

   task automatic check_outputs();
      int    ent = entries();
      beat_t e   = '{32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      if (q.size() > 0) e = q[0];
      chk("in_ready",  in_ready,  resetn && ent < DEPTH);
      chk("count",     count,     ent);
      chk("count_max", count <= DEPTH, 1);
      chk("bus_valid", bus_valid, q.size() > 0);
      chk("bus_data",  bus_data,  e.data);
      chk("bus_last",  bus_last,  e.last);
      chk("bus_hi",    bus_hi,    e.hi);
      chk("bus_err",   bus_err,   e.err);
      chk("bus_zero",  bus_zero,  e.zero);
   endtask

   // Check at negedge, advance the model across the next posedge, return
   // with inputs free to change #1 after that edge.
   task automatic step();
      beat_t b;
      int    ent;
      @(negedge clk);
      check_outputs();
      did_push = 1'b0;
      ent = entries();
      if (!resetn) begin
         q.delete();
      end else begin
         if (q.size() > 0 && bus_ready) b = q.pop_front();
         if (in_valid && ent < DEPTH) begin
            model_push(in_sel, in_result);
            did_push = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] s, input logic [63:0] r);
      in_valid  = 1'b1;
      in_sel    = s;
      in_result = r;
      for (int i = 0; i < 20; i++) begin
         step();
         if (did_push) break;
      end
      if (!did_push) chk("push_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      resetn    = 1'b0;
      in_valid  = 1'b0;
      in_sel    = '0;
      in_result = '0;
      bus_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      step();                       // reset state while resetn low
      resetn = 1'b1;
      idle(1);

      // single narrow beat
      bus_ready = 1'b1;
      send(5'd0, 64'h5);
      idle(2);

      // wide result: low then high
      send(5'd2, 64'h1234_5678_9ABC_DEF0);
      idle(3);

      // fill while stalled, third entry held until space frees
      bus_ready = 1'b0;
      send(5'd0, 64'h1111);
      send(5'd1, 64'h2222);
      in_valid = 1'b1; in_sel = 5'd4; in_result = 64'h3333;
      idle(2);
      chk("full_in_ready", in_ready, 0);
      chk("full_count", count, 2);
      bus_ready = 1'b1;
      send(5'd4, 64'h3333);
      idle(4);

      // zero wide result, stalled
      bus_ready = 1'b0;
      send(5'd3, 64'h0);
      idle(3);
      bus_ready = 1'b1;
      idle(4);

      // illegal opcode
      send(5'd15, 64'hFFFF);
      idle(3);

      // reset mid-drain of a wide result
      send(5'd2, 64'hAAAA_BBBB_CCCC_DDDD);
      step();                       // low beat consumed
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_count", count, 0);
      send(5'd2, 64'h0102_0304_0506_0708);
      idle(3);

      // randomized traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         if (!in_valid || did_push) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 5));
            in_result = ($urandom_range(0, 7) == 0) ? 64'd0
                        : {($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom), 32'($urandom)};
         end
         bus_ready = ($urandom_range(0, 2) != 0);
         resetn    = ($urandom_range(0, 199) != 0);
         step();
      end
      resetn = 1'b1;
      in_valid = 1'b0;
      bus_ready = 1'b1;
      idle(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
